reg_file_32x32: RTL

//  MIPS integer register file: 32 x 32-bit, two async read ports, one sync write port.

---
 rtl/mips_pkg.sv | 9 +
 rtl/dec5to32.sv | 11 +
 rtl/reg_file_32x32.sv | 50 +++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath widths, register-file constants and word/address types.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regaddr_t;
    localparam regaddr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/dec5to32.sv
// dec5to32: 5-to-32 one-hot decoder selecting the register-file write target.
module dec5to32
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0] Adr,
    output logic [NREGS-1:0]  Out
);
    for (genvar i = 0; i < NREGS; i++) begin : g_dec
        assign Out[i] = (Adr == ADDR_W'(i));
    end
endmodule

// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32x32 MIPS register file, two async read ports, one sync write port.
// Define RF_BYPASS_EN to forward Din to a read port addressing the register being written.
module reg_file_32x32
    import mips_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              Wr_En,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2
);
    logic [NREGS-1:0] wsel;
    logic [NREGS-1:0] we;
    word_t            rf [NREGS];
    word_t            rd1;
    word_t            rd2;

    dec5to32 u_wdec (.Adr(Awr), .Out(wsel));

    // register 0 never takes a write enable, so it stays at its reset value of zero
    assign we = {wsel[NREGS-1:1] & {(NREGS-1){Wr_En}}, 1'b0};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) if (we[i]) rf[i] <= Din;
        end
    end

    assign rd1 = (Ard1 == REG_ZERO) ? '0 : rf[Ard1];
    assign rd2 = (Ard2 == REG_ZERO) ? '0 : rf[Ard2];

`ifdef RF_BYPASS_EN
    logic byp1;
    logic byp2;
    // a reset in progress wins over write-through so reads stay zero
    assign byp1  = Wr_En && !Rst && (Awr != REG_ZERO) && (Ard1 == Awr);
    assign byp2  = Wr_En && !Rst && (Awr != REG_ZERO) && (Ard2 == Awr);
    assign Dout1 = byp1 ? Din : rd1;
    assign Dout2 = byp2 ? Din : rd2;
`else
    assign Dout1 = rd1;
    assign Dout2 = rd2;
`endif
endmodule
